mem_arbiter: RTL and testbench

- Arbitrates the single shared RAM1/UART port (the ram_uart controller) between the instruction-fetch requester (IF) and the memory-stage requester (MEM).
- Serializes transactions onto the port's token handshake: a new request is signalled by changing `dev_act`, and completion is signalled by `dev_done`.
- Returns read data and a one-cycle ack to the winning requester, and drives per-requester stall outputs to the pipeline hazard logic.
- Sits between the pipeline stages and ram_uart.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_mem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of signals between mem_arbiter, the two pipeline requesters and the ram_uart port.
// The slave modport is the arbiter's view; master is the pipeline/device side.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              stall_if;
  logic              stall_mem;

  logic              dev_need_to_work;
  logic              dev_rd;
  logic              dev_wr;
  logic [ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic [31:0]       dev_act;
  logic              dev_done;
  logic [DATA_W-1:0] dev_result;

  logic              proto_err;
  logic              timeout_err;

  modport slave (
    input  if_req, if_addr, mem_req, mem_rd, mem_wr, mem_addr, mem_wdata, dev_done, dev_result,
    output if_ack, if_rdata, mem_ack, mem_rdata, stall_if, stall_mem,
    output dev_need_to_work, dev_rd, dev_wr, dev_addr, dev_wdata, dev_act,
    output proto_err, timeout_err
  );

  modport master (
    output if_req, if_addr, mem_req, mem_rd, mem_wr, mem_addr, mem_wdata, dev_done, dev_result,
    input  if_ack, if_rdata, mem_ack, mem_rdata, stall_if, stall_mem,
    input  dev_need_to_work, dev_rd, dev_wr, dev_addr, dev_wdata, dev_act,
    input  proto_err, timeout_err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the shared ram_uart port between instruction fetch and the memory stage,
// issuing each transaction by bumping a 32-bit token and completing on dev_done.
module mem_arbiter #(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_STREAK = 4,
  parameter int unsigned TIMEOUT    = 65535
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;

  localparam logic OwnIf  = 1'b0;
  localparam logic OwnMem = 1'b1;

  localparam int unsigned StreakW = $clog2(MEM_STREAK + 1);

  logic [1:0]         state_q, state_d;
  logic               owner_q, owner_d;
  logic               need_q, need_d;
  logic               rd_q, rd_d;
  logic               wr_q, wr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               if_ack_q, if_ack_d;
  logic               mem_ack_q, mem_ack_d;
  logic [DATA_W-1:0]  if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]  mem_rdata_q, mem_rdata_d;
  logic               proto_q, proto_d;
  logic               tmo_q, tmo_d;
  logic [StreakW-1:0] streak_q, streak_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               mem_sel, if_sel, act_inc;

  // Token survives reset so a late done from an aborted transaction can never match.
  logic [31:0]        dev_act_q = '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    need_d      = need_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    proto_d     = proto_q;
    tmo_d       = tmo_q;
    streak_d    = streak_q;
    cnt_d       = cnt_q;
    act_inc     = 1'b0;

    mem_sel = bus.mem_req && ((32'(streak_q) < MEM_STREAK) || !bus.if_req);
    if_sel  = bus.if_req && !mem_sel;

    case (state_q)
      StIdle: begin
        if (mem_sel) begin
          if (bus.mem_rd == bus.mem_wr) begin
            proto_d     = 1'b1;
            mem_ack_d   = 1'b1;
            mem_rdata_d = '0;
          end else begin
            owner_d = OwnMem;
            rd_d    = bus.mem_rd;
            wr_d    = bus.mem_wr;
            addr_d  = bus.mem_addr;
            wdata_d = bus.mem_wdata;
            need_d  = 1'b1;
            act_inc = 1'b1;
            state_d = StIssue;
          end
        end else if (if_sel) begin
          owner_d = OwnIf;
          rd_d    = 1'b1;
          wr_d    = 1'b0;
          addr_d  = bus.if_addr;
          wdata_d = '0;
          need_d  = 1'b1;
          act_inc = 1'b1;
          state_d = StIssue;
        end
      end
      // One cycle so the device can see the new token on its negedge before done counts.
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        if (bus.dev_done) begin
          need_d  = 1'b0;
          state_d = StIdle;
          if (owner_q == OwnMem) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = bus.dev_result;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.dev_result;
          end
        end else if ((TIMEOUT != 0) && ((cnt_q + 32'd1) == TIMEOUT)) begin
          tmo_d   = 1'b1;
          need_d  = 1'b0;
          state_d = StIdle;
          if (owner_q == OwnMem) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = '0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (!bus.if_req) begin
      streak_d = '0;
    end else if (state_q == StIdle && if_sel) begin
      streak_d = '0;
    end else if (state_q == StIdle && mem_sel) begin
      streak_d = streak_q + StreakW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      need_q      <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      if_ack_q    <= 1'b0;
      mem_ack_q   <= 1'b0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
      proto_q     <= 1'b0;
      tmo_q       <= 1'b0;
      streak_q    <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      need_q      <= need_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      if_ack_q    <= if_ack_d;
      mem_ack_q   <= mem_ack_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
      proto_q     <= proto_d;
      tmo_q       <= tmo_d;
      streak_q    <= streak_d;
      cnt_q       <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && act_inc) begin
      dev_act_q <= dev_act_q + 32'd1;
    end
  end

  assign bus.if_ack           = if_ack_q;
  assign bus.if_rdata         = if_rdata_q;
  assign bus.mem_ack          = mem_ack_q;
  assign bus.mem_rdata        = mem_rdata_q;
  assign bus.stall_if         = rst & bus.if_req & ~if_ack_q;
  assign bus.stall_mem        = rst & bus.mem_req & ~mem_ack_q;
  assign bus.dev_need_to_work = need_q;
  assign bus.dev_rd           = rd_q;
  assign bus.dev_wr           = wr_q;
  assign bus.dev_addr         = addr_q;
  assign bus.dev_wdata        = wdata_q;
  assign bus.dev_act          = dev_act_q;
  assign bus.proto_err        = proto_q;
  assign bus.timeout_err      = tmo_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: stimulus pushes expected acks into a scoreboard,
// a negedge monitor pops and compares them; a small negedge device model answers requests.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  mem_arbiter #(
    .ADDR_W(16), .DATA_W(16), .MEM_STREAK(4), .TIMEOUT(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct packed {
    logic        is_mem;
    logic [15:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Device model state
  logic [31:0] seen_act   = '0;
  logic [31:0] done_tok   = '0;
  int          dcnt       = 0;
  logic        done_valid = 1'b0;
  logic [15:0] done_val   = '0;
  logic [15:0] cur_addr   = '0;
  int          dev_delay  = 3;
  bit          dev_hang   = 1'b0;
  bit          force_done = 1'b0;
  logic [15:0] force_val  = '0;

  assign bus.dev_done   = force_done || (done_valid && (done_tok == bus.dev_act));
  assign bus.dev_result = force_done ? force_val : done_val;

  function automatic logic [15:0] dev_model(input logic [15:0] a);
    return (a == 16'h0010) ? 16'hABCD : ~a;
  endfunction

  always @(negedge clk) begin
    if (bus.dev_act != seen_act) begin
      seen_act <= bus.dev_act;
      dcnt     <= (bus.dev_need_to_work && !dev_hang) ? dev_delay : 0;
      cur_addr <= bus.dev_addr;
    end else if (dcnt != 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) begin
        done_val   <= dev_model(cur_addr);
        done_tok   <= seen_act;
        done_valid <= 1'b1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic is_mem, input logic [15:0] rdata);
    exp_t e;
    e.is_mem = is_mem;
    e.rdata  = rdata;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst && (bus.if_ack || bus.mem_ack)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected_ack: got if_ack=%0b mem_ack=%0b expected none",
                 bus.if_ack, bus.mem_ack);
      end else begin
        mon_e = sb.pop_front();
        check("sb_owner", {31'd0, bus.mem_ack}, {31'd0, mon_e.is_mem});
        check("sb_rdata", {16'd0, bus.mem_ack ? bus.mem_rdata : bus.if_rdata},
              {16'd0, mon_e.rdata});
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Waits for the requester's ack, checks its stall drops with it, then withdraws req.
  task automatic wait_ack(input bit is_mem, output int lat);
    lat = 0;
    for (int i = 0; i < 64; i++) begin
      cyc();
      lat++;
      if (is_mem ? bus.mem_ack : bus.if_ack) begin
        check(is_mem ? "stall_mem_at_ack" : "stall_if_at_ack",
              {31'd0, is_mem ? bus.stall_mem : bus.stall_if}, 32'd0);
        if (is_mem) bus.mem_req = 1'b0;
        else        bus.if_req  = 1'b0;
        return;
      end
    end
    check(is_mem ? "mem_ack_wait_expired" : "if_ack_wait_expired", 32'd0, 32'd1);
    lat = -1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  logic [31:0] a0;
  int          lat;
  int          n;

  initial begin
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_req   = 1'b1;  // must be ignored while in reset
    bus.mem_rd    = 1'b1;
    a0 = bus.dev_act;
    cyc(); cyc(); cyc();
    check("rst_stall_mem", {31'd0, bus.stall_mem}, 32'd0);
    check("rst_act_hold", bus.dev_act, a0);
    bus.mem_req = 1'b0;
    bus.mem_rd  = 1'b0;
    rst = 1'b1;
    cyc();
    check("rst_ctrl", {27'd0, bus.if_ack, bus.mem_ack, bus.dev_need_to_work, bus.dev_rd,
                       bus.dev_wr}, 32'd0);
    check("rst_addr_wdata", {bus.dev_addr, bus.dev_wdata}, 32'd0);
    check("rst_rdata", {bus.if_rdata, bus.mem_rdata}, 32'd0);
    check("rst_err", {30'd0, bus.proto_err, bus.timeout_err}, 32'd0);

    // IF-only read
    dev_delay   = 3;
    a0          = bus.dev_act;
    bus.if_addr = 16'h0010;
    push(1'b0, 16'hABCD);
    bus.if_req  = 1'b1;
    cyc();
    check("t1_act", bus.dev_act, a0 + 32'd1);
    check("t1_rd_wr_need", {29'd0, bus.dev_rd, bus.dev_wr, bus.dev_need_to_work}, 32'd5);
    check("t1_addr", {16'd0, bus.dev_addr}, 32'h0010);
    check("t1_stall", {31'd0, bus.stall_if}, 32'd1);
    wait_ack(1'b0, lat);
    check("t1_latency", lat, 32'd4);
    cyc();
    check("t1_ack_pulse", {31'd0, bus.if_ack}, 32'd0);
    check("t1_rdata_hold", {16'd0, bus.if_rdata}, 32'h0000ABCD);
    check("t1_need_clear", {31'd0, bus.dev_need_to_work}, 32'd0);

    // Simultaneous IF read and MEM write: MEM first, IF granted in mem_ack cycle
    a0            = bus.dev_act;
    bus.if_addr   = 16'h0020;
    bus.mem_addr  = 16'hBF00;
    bus.mem_wdata = 16'h0041;
    bus.mem_rd    = 1'b0;
    bus.mem_wr    = 1'b1;
    push(1'b1, 16'h40FF);
    push(1'b0, 16'hFFDF);
    bus.if_req  = 1'b1;
    bus.mem_req = 1'b1;
    cyc();
    check("t2_act_mem", bus.dev_act, a0 + 32'd1);
    check("t2_wr_rd", {30'd0, bus.dev_wr, bus.dev_rd}, 32'd2);
    check("t2_addr_wdata", {bus.dev_addr, bus.dev_wdata}, 32'hBF000041);
    wait_ack(1'b1, lat);
    cyc();
    check("t2_act_if", bus.dev_act, a0 + 32'd2);
    check("t2_if_addr", {16'd0, bus.dev_addr}, 32'h0020);
    check("t2_if_rd", {31'd0, bus.dev_rd}, 32'd1);
    wait_ack(1'b0, lat);
    cyc();
    check("t2_two_tokens", bus.dev_act, a0 + 32'd2);

    // Continuous MEM reads while IF waits: MEM x4, IF, MEM
    dev_delay    = 2;
    bus.mem_addr = 16'h0100;
    bus.mem_rd   = 1'b1;
    bus.mem_wr   = 1'b0;
    bus.if_addr  = 16'h0030;
    for (int i = 0; i < 4; i++) push(1'b1, 16'hFEFF);
    push(1'b0, 16'hFFCF);
    push(1'b1, 16'hFEFF);
    bus.mem_req = 1'b1;
    bus.if_req  = 1'b1;
    n = 0;
    for (int i = 0; i < 200 && n < 6; i++) begin
      cyc();
      if (bus.if_ack) begin
        bus.if_req = 1'b0;
        n++;
      end
      if (bus.mem_ack) begin
        n++;
        if (n == 6) bus.mem_req = 1'b0;
      end
    end
    check("t3_ack_count", n, 32'd6);
    cyc(); cyc();

    // Protocol error: rd == wr
    a0           = bus.dev_act;
    bus.mem_addr = 16'h0080;
    bus.mem_rd   = 1'b1;
    bus.mem_wr   = 1'b1;
    push(1'b1, 16'h0000);
    bus.mem_req  = 1'b1;
    cyc();
    check("t4_ack_next_cycle", {31'd0, bus.mem_ack}, 32'd1);
    bus.mem_req = 1'b0;
    cyc();
    check("t4_proto_err", {31'd0, bus.proto_err}, 32'd1);
    check("t4_no_token", bus.dev_act, a0);
    check("t4_no_need", {31'd0, bus.dev_need_to_work}, 32'd0);

    // Timeout with the device hung
    dev_hang    = 1'b1;
    bus.if_addr = 16'h0040;
    push(1'b0, 16'h0000);
    bus.if_req  = 1'b1;
    cyc();
    check("t5_tmo_clear_before", {31'd0, bus.timeout_err}, 32'd0);
    wait_ack(1'b0, lat);
    check("t5_latency", lat, 32'd9);
    cyc();
    check("t5_timeout_err", {31'd0, bus.timeout_err}, 32'd1);
    dev_hang     = 1'b0;
    a0           = bus.dev_act;
    bus.mem_addr = 16'h0050;
    bus.mem_rd   = 1'b1;
    bus.mem_wr   = 1'b0;
    push(1'b1, 16'hFFAF);
    bus.mem_req  = 1'b1;
    cyc();
    check("t5_new_token", bus.dev_act, a0 + 32'd1);
    wait_ack(1'b1, lat);
    check("t5_after_latency", lat, 32'd3);

    // Reset in WAIT, then a stale done presented during ISSUE
    dev_delay   = 6;
    a0          = bus.dev_act;
    bus.if_addr = 16'h0060;
    bus.if_req  = 1'b1;
    cyc();
    check("t6_act", bus.dev_act, a0 + 32'd1);
    cyc(); cyc();
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_ctrl", {28'd0, bus.dev_need_to_work, bus.dev_rd, bus.if_ack, bus.stall_if},
          32'd0);
    check("t6_rst_addr", {16'd0, bus.dev_addr}, 32'd0);
    check("t6_act_kept", bus.dev_act, a0 + 32'd1);
    bus.if_req = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) cyc();
    dev_delay   = 3;
    bus.if_addr = 16'h0070;
    force_done  = 1'b1;
    force_val   = 16'hDEAD;
    push(1'b0, 16'hFF8F);
    bus.if_req  = 1'b1;
    cyc();
    check("t6_new_token", bus.dev_act, a0 + 32'd2);
    cyc();
    force_done = 1'b0;
    check("t6_no_early_ack", {31'd0, bus.if_ack}, 32'd0);
    wait_ack(1'b0, lat);
    check("t6_latency", lat, 32'd3);

    for (int i = 0; i < 5; i++) cyc();
    check("sb_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
